// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode encoding and datapath width for the RISC ALU
package risc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

endpackage

// File: rtl/risc_addsub.sv
// rtl/risc_addsub.sv - shared adder/subtractor with signed overflow detection
module risc_addsub
  import risc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] cin;

  assign b_eff = sub ? ~b : b;
  assign cin   = {{(WIDTH-1){1'b0}}, sub};
  assign sum   = a + b_eff + cin;

  // Overflow on the effective addend covers both ADD and SUB: same-sign inputs, differing result.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/risc_alu.sv
// rtl/risc_alu.sv - 16-bit ALU with registered result and Z/N/V status flags
module risc_alu
  import risc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] result;
  logic             result_ovf;

  assign op = alu_op_e'(ALUop);

  risc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (Ain),
    .b   (Bin),
    .sub (op == ALU_SUB),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    result     = '0;
    result_ovf = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        result     = sum;
        result_ovf = sum_ovf;
      end
      ALU_AND: result = Ain & Bin;
      ALU_NOT: result = ~Bin;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
      Z   <= 1'b0;
      N   <= 1'b0;
      V   <= 1'b0;
    end else if (en) begin
      out <= result;
      Z   <= (result == '0);
      N   <= result[WIDTH-1];
      V   <= result_ovf;
    end
  end

endmodule

// File: tb/tb_risc_alu.sv
// tb/tb_risc_alu.sv - directed scoreboard bench for risc_alu
module tb_risc_alu;

  typedef struct packed {
    logic [15:0] o;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Ain = '0;
  logic [15:0] Bin = '0;
  logic [1:0]  ALUop = '0;
  logic        en = 1'b0;
  logic [15:0] out;
  logic        Z;
  logic        N;
  logic        V;

  exp_t sb_q[$];
  exp_t held;
  int   checks = 0;
  int   passed = 0;

  risc_alu dut (
    .clk   (clk),
    .reset (reset),
    .Ain   (Ain),
    .Bin   (Bin),
    .ALUop (ALUop),
    .en    (en),
    .out   (out),
    .Z     (Z),
    .N     (N),
    .V     (V)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int          sa;
    int          sb;
    int          r;
    logic [15:0] res;
    logic        v;
    exp_t        e;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = 0;
    v   = 1'b0;
    res = '0;
    case (op)
      2'b00: begin r = sa + sb; res = r[15:0]; v = (r > 32767) || (r < -32768); end
      2'b01: begin r = sa - sb; res = r[15:0]; v = (r > 32767) || (r < -32768); end
      2'b10: res = a & b;
      default: res = ~b;
    endcase
    e.o = res;
    e.z = (res == 16'h0000);
    e.n = res[15];
    e.v = v;
    return e;
  endfunction

  task automatic check(input string tag, input exp_t exp);
    exp_t obs;
    obs = {out, Z, N, V};
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed out=%h ZNV=%b%b%b expected out=%h ZNV=%b%b%b",
                tag, obs.o, obs.z, obs.n, obs.v, exp.o, exp.z, exp.n, exp.v);
  endtask

  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input logic e);
    @(negedge clk);
    Ain   = a;
    Bin   = b;
    ALUop = op;
    en    = e;
    if (e) sb_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
    if (e) begin
      if (sb_q.size() > 0) begin
        held = sb_q.pop_front();
      end else begin
        checks++;
        $error("FAIL %s_queue: observed empty expected entry", tag);
      end
    end
    check(tag, held);
  endtask

  initial begin
    held = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0);
    @(negedge clk);
    reset = 1'b0;

    step("add",        16'h0F80, 16'h0070, 2'b00, 1'b1);
    step("sub_equal",  16'h0F80, 16'h0F80, 2'b01, 1'b1);
    step("and",        16'h0FA4, 16'h0F90, 2'b10, 1'b1);
    step("not",        16'h0FA4, 16'h0F90, 2'b11, 1'b1);
    step("zero_add",   16'h0000, 16'h0000, 2'b00, 1'b1);
    step("zero_sub",   16'h0000, 16'h0000, 2'b01, 1'b1);
    step("zero_and",   16'h0000, 16'h0000, 2'b10, 1'b1);
    step("zero_not",   16'h0000, 16'h0000, 2'b11, 1'b1);
    step("add_ovf",    16'h7FFF, 16'h0001, 2'b00, 1'b1);
    step("add_wrap",   16'hFFFF, 16'h0001, 2'b00, 1'b1);
    step("sub_ovf",    16'h8000, 16'h0001, 2'b01, 1'b1);
    step("sub_ovf_neg",16'h7FFF, 16'hFFFF, 2'b01, 1'b1);
    step("add_neg",    16'hFFF0, 16'hFFF0, 2'b00, 1'b1);
    step("sub_borrow", 16'h0001, 16'h0002, 2'b01, 1'b1);
    step("hold_ops",   16'h1234, 16'h4321, 2'b00, 1'b0);
    step("hold_opc",   16'h0000, 16'h0000, 2'b11, 1'b0);
    step("add_after",  16'h1234, 16'h4321, 2'b00, 1'b1);

    @(negedge clk);
    en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    held = '0;
    check("async_reset", held);

    @(negedge clk);
    Ain   = 16'h7FFF;
    Bin   = 16'h0001;
    ALUop = 2'b00;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check("reset_wins", held);

    @(negedge clk);
    en    = 1'b0;
    reset = 1'b0;
    step("post_reset", 16'h7FFF, 16'h0001, 2'b00, 1'b1);
    step("post_hold",  16'h0001, 16'h0001, 2'b01, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/risc_alu.md
Name: risc_alu

Overview:
- 16-bit arithmetic/logic unit for the RISC machine datapath.
- Sits between the A/B operand registers and the C/status registers.
- Computes add, subtract, bitwise AND or bitwise NOT of B, selected by a 2-bit opcode.
- Result and status flags are registered: one clock, asynchronous active-high reset.

Parameters:
- WIDTH, 16, datapath width in bits for operands and result.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Ain  input  WIDTH  operand A
- Bin  input  WIDTH  operand B
- ALUop  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 NOT
- en  input  1  load enable; result and flags update only when 1
- out  output  WIDTH  registered result
- Z  output  1  registered zero flag
- N  output  1  registered negative flag (MSB of result)
- V  output  1  registered signed-overflow flag

Behaviour:
- Reset asserted (asynchronous): out=0, Z=0, N=0, V=0 immediately; held while reset=1.
- Operation results:
  - ADD: Ain+Bin modulo 2^WIDTH; carry-out discarded.
  - SUB: Ain-Bin modulo 2^WIDTH, computed as Ain + ~Bin + 1.
  - AND: bitwise Ain & Bin.
  - NOT: bitwise ~Bin; Ain is ignored.
- Latency and update:
  - When en=1 at a rising clk edge (reset low), out takes the combinational result; latency is exactly 1 cycle.
  - When en=0, out, Z, N and V all hold their previous values.
- Flags (computed from the same result, updated together with out):
  - Z = 1 iff the result is all zeros.
  - N = result[WIDTH-1].
  - V for ADD = operands have the same sign and the result sign differs.
  - V for SUB = operands have different signs and the result sign differs from Ain.
  - V = 0 for AND and NOT.
- Wrap-around: 0xFFFF+0x0001 gives out=0x0000, Z=1, V=0. 0x7FFF+0x0001 gives 0x8000, N=1, V=1.
- Operand or opcode changes between edges have no effect until the next enabled edge.
- No X propagation: every ALUop encoding is defined.
- Reset mid-operation:
  - Reset asserted together with en=1 at an edge: reset wins, outputs are 0.
  - After reset deasserts, the first enabled edge loads a fresh result.

Decomposition:
- Shared package risc_pkg holds:
  - alu_op_e enum: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_NOT=2'b11.
  - localparam DATA_W=16, used as the WIDTH default.
- One sub-module, risc_addsub:
  - Shared WIDTH-bit adder with a sub control (inverts B, carry-in 1).
  - Outputs sum and signed overflow.
- The top-level handles op muxing, flag generation and the output registers.

Test Plan:
- ADD: Ain=0x0F80, Bin=0x0070, op=00, en=1 -> next edge out=0x0FF0, Z=0, N=0, V=0.
- SUB equal operands: Ain=Bin=0x0F80, op=01 -> out=0x0000, Z=1, N=0, V=0.
- AND then NOT, Ain=0x0FA4, Bin=0x0F90:
  - op=10 -> out=0x0F80, Z=0.
  - op=11 -> out=0xF06F, N=1, Z=0.
- Zero operands, Ain=Bin=0x0000, ops 00/01/10/11 in sequence:
  - ADD, SUB, AND -> out=0x0000, Z=1.
  - NOT -> out=0xFFFF, Z=0, N=1.
- Overflow and wrap:
  - 0x7FFF+0x0001 -> 0x8000, V=1, N=1.
  - 0xFFFF+0x0001 -> 0x0000, Z=1, V=0.
  - SUB 0x8000-0x0001 -> 0x7FFF, V=1.
- Enable and reset:
  - With en=0, change operands -> outputs hold.
  - Assert reset mid-cycle (asynchronously) with a nonzero out -> out, Z, N, V go to 0 before the next edge.
  - After release, the first en=1 edge produces the correct result.
